// File: rtl/alu_srcb_stage.sv
// ALU operand-B selector with a two-entry skid buffer.
// Operands are formed from register_b, a step constant or the immediate and handed to the ALU over valid/ready.
module alu_srcb_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int STEP      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     register_b,
    input  logic [IMM_WIDTH-1:0] immediate,
    input  logic [5:0]           opcode,
    input  logic [2:0]           alusrcb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_operand,
    output logic                 bad_mode
);

    localparam int EXT_W = WIDTH - IMM_WIDTH;

    // Logical immediates (ANDI/ORI/XORI) zero-extend; all other opcodes sign-extend.
    function automatic logic [WIDTH-1:0] extend_imm(input logic [IMM_WIDTH-1:0] imm,
                                                    input logic [5:0] opc);
        logic [WIDTH-1:0] ext;
        case (opc)
            6'h0C, 6'h0D, 6'h0E: ext = {{EXT_W{1'b0}}, imm};
            default:             ext = {{EXT_W{imm[IMM_WIDTH-1]}}, imm};
        endcase
        return ext;
    endfunction

    function automatic logic [WIDTH-1:0] select_operand(input logic [WIDTH-1:0]     rb,
                                                        input logic [IMM_WIDTH-1:0] imm,
                                                        input logic [5:0]           opc,
                                                        input logic [2:0]           mode);
        logic [WIDTH-1:0] ext;
        logic [WIDTH-1:0] op;
        ext = extend_imm(imm, opc);
        case (mode)
            3'd0:    op = rb;
            3'd1:    op = WIDTH'(STEP);
            3'd2:    op = ext;
            3'd3:    op = {ext[WIDTH-3:0], 2'b00};
            3'd4:    op = {imm, {EXT_W{1'b0}}};
            default: op = {WIDTH{1'b0}};
        endcase
        return op;
    endfunction

    logic             main_valid_r;
    logic [WIDTH-1:0] main_data_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             bad_mode_r;

    logic [WIDTH-1:0] operand_s;
    logic             accept_s;
    logic             drain_s;
    logic             bad_req_s;

    // Operand formation and handshake qualification; flush blocks both accept and drain.
    always_comb begin
        operand_s = select_operand(register_b, immediate, opcode, alusrcb);
        accept_s  = in_valid & ~skid_valid_r & ~flush;
        drain_s   = main_valid_r & out_ready & ~flush;
        if (alusrcb >= 3'd5) begin
            bad_req_s = 1'b1;
        end else begin
            bad_req_s = 1'b0;
        end
    end

    // Main/skid occupancy and main data; main data is kept at zero while main is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
        end else if (drain_s && skid_valid_r) begin
            // in_ready is low here, so no accept can coincide with this refill
            main_data_r  <= skid_data_r;
            skid_valid_r <= 1'b0;
        end else if (drain_s) begin
            main_valid_r <= accept_s;
            main_data_r  <= accept_s ? operand_s : {WIDTH{1'b0}};
        end else if (accept_s && main_valid_r) begin
            skid_valid_r <= 1'b1;
        end else if (accept_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= operand_s;
        end
    end

    // Skid payload needs no reset; its valid bit alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept_s && main_valid_r && !drain_s) begin
            skid_data_r <= operand_s;
        end
    end

    // Sticky illegal-mode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_mode_r <= 1'b0;
        end else if (accept_s && bad_req_s) begin
            bad_mode_r <= 1'b1;
        end
    end

    assign in_ready    = ~skid_valid_r;
    assign out_valid   = main_valid_r;
    assign out_operand = main_data_r;
    assign bad_mode    = bad_mode_r;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Scoreboard bench for alu_srcb_stage: a queue-based occupancy model predicts operands,
// in_ready and bad_mode; a negedge monitor compares and retires entries.
module tb_alu_srcb_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, bad_mode;
    logic [31:0] register_b, out_operand;
    logic [15:0] immediate;
    logic [5:0]  opcode;
    logic [2:0]  alusrcb;

    logic        in_valid2, in_ready2, out_valid2, bad_mode2;
    logic [63:0] register_b2, out_operand2;
    logic [15:0] immediate2;
    logic [5:0]  opcode2;
    logic [2:0]  alusrcb2;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic        started   = 1'b0;
    logic        ready_exp = 1'b1;
    logic        bad_exp   = 1'b0;
    logic        acc_last  = 1'b0;

    alu_srcb_stage #(.WIDTH(32), .IMM_WIDTH(16), .STEP(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .register_b(register_b), .immediate(immediate), .opcode(opcode), .alusrcb(alusrcb),
        .out_valid(out_valid), .out_ready(out_ready), .out_operand(out_operand), .bad_mode(bad_mode)
    );

    alu_srcb_stage #(.WIDTH(64), .IMM_WIDTH(16), .STEP(8)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
        .register_b(register_b2), .immediate(immediate2), .opcode(opcode2), .alusrcb(alusrcb2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_operand(out_operand2), .bad_mode(bad_mode2)
    );

    always #5 clk = ~clk;

    // Reference operand from the arithmetic definition of each mode.
    function automatic logic [63:0] ref_operand(input int w, input int step, input logic [63:0] rb,
                                                input logic [15:0] imm, input logic [5:0] opc,
                                                input logic [2:0] mode);
        logic [63:0] mask, ext, imm64;
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        imm64 = {48'd0, imm};
        if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E || imm < 16'h8000) ext = imm64;
        else ext = (mask - 64'hFFFF) + imm64;
        case (mode)
            3'd0:    return rb & mask;
            3'd1:    return 64'(step);
            3'd2:    return ext;
            3'd3:    return (ext * 64'd4) & mask;
            3'd4:    return (imm64 << (w - 16)) & mask;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model head, then retire on drain.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            chk("out_operand", {32'd0, out_operand}, {32'd0, (q.size() > 0) ? q[0] : 32'd0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("bad_mode", {63'd0, bad_mode}, {63'd0, bad_exp});
            ready_exp = (q.size() < 2);
            if (reset || flush) q.delete();
            else if (q.size() > 0 && out_ready) void'(q.pop_front());
        end
    end

    // Predictor: push the expected operand for every request the model accepts.
    always @(negedge clk) begin
        #1;
        acc_last = 1'b0;
        if (started) begin
            if (reset) begin
                bad_exp = 1'b0;
            end else if (!flush && in_valid && ready_exp) begin
                acc_last = 1'b1;
                q.push_back(ref_operand(32, 4, {32'd0, register_b}, immediate, opcode, alusrcb)[31:0]);
                if (alusrcb >= 3'd5) bad_exp = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] rb, input logic [15:0] imm, input logic [5:0] opc,
                         input logic [2:0] mode, input logic [31:0] exp, input string name);
        in_valid = 1'b1; register_b = rb; immediate = imm; opcode = opc; alusrcb = mode;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk(name, {32'd0, out_operand}, {32'd0, exp});
    endtask

    initial begin
        int k;
        int cnt;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        register_b = 32'd0; immediate = 16'd0; opcode = 6'd0; alusrcb = 3'd0;
        in_valid2 = 1'b0; register_b2 = 64'd0; immediate2 = 16'd0; opcode2 = 6'd0; alusrcb2 = 3'd0;
        cyc();
        reset = 1'b0;
        started = 1'b1;
        cyc();

        // Extension and mode vectors
        issue(32'd0, 16'h8001, 6'h08, 3'd2, 32'hFFFF8001, "mode2_sext");
        issue(32'd0, 16'h8001, 6'h0D, 3'd2, 32'h00008001, "mode2_zext");
        issue(32'd0, 16'h8001, 6'h08, 3'd3, 32'hFFFE0004, "mode3");
        issue(32'd0, 16'h8001, 6'h08, 3'd4, 32'h80010000, "mode4_lui");
        issue(32'd0, 16'h8001, 6'h08, 3'd1, 32'h00000004, "mode1_step");
        issue(32'hDEADBEEF, 16'h8001, 6'h08, 3'd0, 32'hDEADBEEF, "mode0_reg");

        // Backpressure: operands 1..6 with out_ready low in cycles 2..5
        k = 1;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid = (k <= 6); register_b = k; alusrcb = 3'd0;
            cyc();
            if (acc_last) k++;
        end
        chk("bp_all_accepted", 64'(k), 64'd7);
        in_valid = 1'b0; out_ready = 1'b1;

        // Full throughput
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; register_b = $urandom; immediate = $urandom;
            opcode = $urandom; alusrcb = $urandom_range(0, 4);
            cyc();
            @(negedge clk);
            if (out_valid) cnt++;
        end
        in_valid = 1'b0;
        chk("throughput_count", 64'(cnt), 64'd100);

        // Bad mode is sticky through flush, cleared by reset
        cyc();
        issue(32'h1234, 16'h5555, 6'h08, 3'd6, 32'd0, "mode6_zero");
        chk("bad_mode_set", {63'd0, bad_mode}, 64'd1);
        flush = 1'b1; cyc(); flush = 1'b0;
        @(negedge clk);
        chk("bad_mode_after_flush", {63'd0, bad_mode}, 64'd1);
        reset = 1'b1; cyc(); reset = 1'b0;
        @(negedge clk);
        chk("bad_mode_after_reset", {63'd0, bad_mode}, 64'd0);

        // Flush with both entries full and a concurrent request
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; register_b = 32'hF00 + i; alusrcb = 3'd0; cyc();
        end
        flush = 1'b1; register_b = 32'hBAD; cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Reset while stalled full, then a fresh request
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; register_b = 32'hA00 + i; alusrcb = 3'd0; cyc();
        end
        in_valid = 1'b0; reset = 1'b1; cyc(); reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_operand", {32'd0, out_operand}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        issue(32'h0000CAFE, 16'd0, 6'd0, 3'd0, 32'h0000CAFE, "post_reset");

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            register_b = $urandom;
            immediate  = $urandom;
            case ($urandom_range(0, 4))
                0: opcode = 6'h0C;
                1: opcode = 6'h0D;
                2: opcode = 6'h0E;
                default: opcode = $urandom;
            endcase
            alusrcb = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // 64-bit instance with STEP=8
        in_valid2 = 1'b1; immediate2 = 16'hFFFF; opcode2 = 6'h08; alusrcb2 = 3'd2;
        cyc();
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("w64_valid", {63'd0, out_valid2}, 64'd1);
        chk("w64_mode2", out_operand2, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid2 = 1'b1; alusrcb2 = 3'd1;
        cyc();
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("w64_mode1", out_operand2, 64'd8);
        in_valid2 = 1'b1; immediate2 = 16'h8001; alusrcb2 = 3'd4;
        cyc();
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("w64_mode4", out_operand2, 64'h8001_0000_0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
